// File: rtl/tc_sram_latch_mp.sv
// rtl/tc_sram_latch_mp.sv - N-port word memory with byte enables, lowest-port write arbitration, 0/1 read latency
// Optional post-reset zeroing engine enabled by defining TC_SRAM_LATCH_MP_INIT_EN
module tc_sram_latch_mp #(
   parameter int NumWords  = 64,
   parameter int DataWidth = 32,
   parameter int ByteWidth = 8,
   parameter int NumPorts  = 2,
   parameter int Latency   = 1,
   parameter int AddrWidth = $clog2(NumWords),
   parameter int BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [NumPorts-1:0]             req_i,
   input  logic [NumPorts-1:0]             we_i,
   input  logic [NumPorts*AddrWidth-1:0]   addr_i,
   input  logic [NumPorts*DataWidth-1:0]   wdata_i,
   input  logic [NumPorts*BeWidth-1:0]     be_i,
   output logic [NumPorts-1:0]             gnt_o,
   output logic [NumPorts*DataWidth-1:0]   rdata_o,
   output logic [NumPorts-1:0]             rvalid_o,
   output logic                            init_done_o
);

   logic [DataWidth-1:0] r_mem [NumWords];

   logic [AddrWidth-1:0] w_addr  [NumPorts];
   logic [DataWidth-1:0] w_wdata [NumPorts];
   logic [DataWidth-1:0] w_mask  [NumPorts];
   logic [DataWidth-1:0] w_rdata [NumPorts];
   logic [NumPorts-1:0]  w_in_range;
   logic [NumPorts-1:0]  w_gnt;
   logic [NumPorts-1:0]  w_rd;
   logic                 w_ready;
   logic                 w_init_we;
   logic [AddrWidth-1:0] w_init_addr;

   // Per-bit write mask; the last lane may be narrower than ByteWidth
   always_comb begin
      for (int p = 0; p < NumPorts; p++) begin
         w_addr[p]     = addr_i[p*AddrWidth +: AddrWidth];
         w_wdata[p]    = wdata_i[p*DataWidth +: DataWidth];
         w_in_range[p] = (int'(w_addr[p]) < NumWords);
         for (int i = 0; i < DataWidth; i++) begin
            w_mask[p][i] = be_i[p*BeWidth + i/ByteWidth];
         end
      end
   end

   // A write loses to any lower-index port writing the same address
   always_comb begin
      for (int p = 0; p < NumPorts; p++) begin
         w_gnt[p] = req_i[p] & w_ready;
         if (we_i[p]) begin
            for (int q = 0; q < p; q++) begin
               if (req_i[q] && we_i[q] && (w_addr[q] == w_addr[p])) begin
                  w_gnt[p] = 1'b0;
               end
            end
         end
         w_rd[p]    = w_gnt[p] & ~we_i[p];
         w_rdata[p] = w_in_range[p] ? r_mem[w_addr[p]] : '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         if (w_init_we) begin
            r_mem[w_init_addr] <= '0;
         end
         for (int p = 0; p < NumPorts; p++) begin
            if (w_gnt[p] && we_i[p] && w_in_range[p]) begin
               r_mem[w_addr[p]] <= (r_mem[w_addr[p]] & ~w_mask[p]) | (w_wdata[p] & w_mask[p]);
            end
         end
      end
   end

`ifdef TC_SRAM_LATCH_MP_INIT_EN
   typedef enum logic {S_INIT, S_READY} state_t;

   state_t               r_state;
   logic [AddrWidth-1:0] r_cnt;
   logic                 r_done;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_INIT;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_INIT: begin
               if (r_cnt == AddrWidth'(NumWords - 1)) begin
                  r_state <= S_READY;
                  r_done  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + AddrWidth'(1);
               end
            end
            default: r_done <= 1'b1;
         endcase
      end
   end

   assign w_init_we   = (r_state == S_INIT);
   assign w_init_addr = r_cnt;
   assign init_done_o = r_done;
`else
   assign w_init_we   = 1'b0;
   assign w_init_addr = '0;
   assign init_done_o = 1'b1;
`endif

   assign w_ready = init_done_o & ~rst_i;
   assign gnt_o   = w_gnt;

   generate
      if (Latency == 0) begin : g_lat0
         always_comb begin
            for (int p = 0; p < NumPorts; p++) begin
               rdata_o[p*DataWidth +: DataWidth] = w_rdata[p];
            end
         end
         assign rvalid_o = w_rd;
      end else begin : g_lat1
         logic [NumPorts*DataWidth-1:0] r_rdata;
         logic [NumPorts-1:0]           r_rvalid;

         // Data lanes only update on a granted read so they hold otherwise
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               r_rdata  <= '0;
               r_rvalid <= '0;
            end else begin
               r_rvalid <= w_rd;
               for (int p = 0; p < NumPorts; p++) begin
                  if (w_rd[p]) begin
                     r_rdata[p*DataWidth +: DataWidth] <= w_rdata[p];
                  end
               end
            end
         end

         assign rdata_o  = r_rdata;
         assign rvalid_o = r_rvalid;
      end
   endgenerate

endmodule

// File: tb/tb_tc_sram_latch_mp.sv
// tb/tb_tc_sram_latch_mp.sv - directed vector bench for tc_sram_latch_mp
// Two instances: 3-port/48-word/latency-1 and 2-port/16-word/12-bit/latency-0
module tb_tc_sram_latch_mp;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic [2:0]  l1_req, l1_we, l1_gnt, l1_rvalid;
   logic [17:0] l1_addr;
   logic [95:0] l1_wdata, l1_rdata;
   logic [11:0] l1_be;
   logic        l1_done;

   logic [1:0]  l0_req, l0_we, l0_gnt, l0_rvalid;
   logic [7:0]  l0_addr;
   logic [23:0] l0_wdata, l0_rdata;
   logic [3:0]  l0_be;
   logic        l0_done;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   tc_sram_latch_mp #(.NumWords(48), .DataWidth(32), .ByteWidth(8), .NumPorts(3), .Latency(1)) u_l1 (
      .clk_i(clk), .rst_i(rst), .req_i(l1_req), .we_i(l1_we), .addr_i(l1_addr),
      .wdata_i(l1_wdata), .be_i(l1_be), .gnt_o(l1_gnt), .rdata_o(l1_rdata),
      .rvalid_o(l1_rvalid), .init_done_o(l1_done)
   );

   tc_sram_latch_mp #(.NumWords(16), .DataWidth(12), .ByteWidth(8), .NumPorts(2), .Latency(0)) u_l0 (
      .clk_i(clk), .rst_i(rst), .req_i(l0_req), .we_i(l0_we), .addr_i(l0_addr),
      .wdata_i(l0_wdata), .be_i(l0_be), .gnt_o(l0_gnt), .rdata_o(l0_rdata),
      .rvalid_o(l0_rvalid), .init_done_o(l0_done)
   );

   typedef struct {
      string            name;
      logic [2:0]       req, we;
      logic [2:0][5:0]  a;
      logic [2:0][31:0] d;
      logic [2:0][3:0]  b;
      logic [2:0]       gnt, rv, chk;
      logic [2:0][31:0] r;
   } vec_t;

   vec_t vt[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!(l0_done && l1_done) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("wait_ready", {30'd0, l1_done, l0_done}, 32'd3);
   endtask

   task automatic count_init(output int n0, output int n1, output int gbad);
      n0 = 0; n1 = 0; gbad = 0;
      for (int n = 1; n <= 200 && !l1_done; n++) begin
         @(posedge clk); #1;
         if (l0_done && n0 == 0) n0 = n;
         if (l1_done && n1 == 0) n1 = n;
         if ((!l0_done && l0_gnt != 0) || (!l1_done && l1_gnt != 0)) gbad++;
      end
   endtask

   initial begin
      int n0, n1, gbad;

      vt[0]  = '{"wr5",    3'b001, 3'b001, {6'd0, 6'd0, 6'd5},    {32'h0, 32'h0, 32'hDEADBEEF}, {4'h0, 4'h0, 4'hF}, 3'b001, 3'b000, 3'b000, '0};
      vt[1]  = '{"rd5",    3'b010, 3'b000, {6'd0, 6'd5, 6'd0},    '0, '0, 3'b010, 3'b010, 3'b010, {32'h0, 32'hDEADBEEF, 32'h0}};
      vt[2]  = '{"wr3",    3'b001, 3'b001, {6'd0, 6'd0, 6'd3},    {32'h0, 32'h0, 32'h11223344}, {4'h0, 4'h0, 4'hF}, 3'b001, 3'b000, 3'b000, '0};
      vt[3]  = '{"wr3be",  3'b001, 3'b001, {6'd0, 6'd0, 6'd3},    {32'h0, 32'h0, 32'hAABBCCDD}, {4'h0, 4'h0, 4'h5}, 3'b001, 3'b000, 3'b000, '0};
      vt[4]  = '{"rd3",    3'b100, 3'b000, {6'd3, 6'd0, 6'd0},    '0, '0, 3'b100, 3'b100, 3'b100, {32'h11BB33DD, 32'h0, 32'h0}};
      vt[5]  = '{"confl",  3'b101, 3'b101, {6'd9, 6'd0, 6'd9},    {32'h2, 32'h0, 32'h1}, {4'hF, 4'h0, 4'hF}, 3'b001, 3'b000, 3'b000, '0};
      vt[6]  = '{"retry",  3'b110, 3'b100, {6'd9, 6'd9, 6'd0},    {32'h2, 32'h0, 32'h0}, {4'hF, 4'h0, 4'h0}, 3'b110, 3'b010, 3'b010, {32'h0, 32'h1, 32'h0}};
      vt[7]  = '{"rd9",    3'b001, 3'b000, {6'd0, 6'd0, 6'd9},    '0, '0, 3'b001, 3'b001, 3'b001, {32'h0, 32'h0, 32'h2}};
      vt[8]  = '{"be0",    3'b010, 3'b010, {6'd0, 6'd5, 6'd0},    '0, '0, 3'b010, 3'b000, 3'b000, '0};
      vt[9]  = '{"rd3x",   3'b111, 3'b000, {6'd50, 6'd3, 6'd5},   '0, '0, 3'b111, 3'b111, 3'b111, {32'h0, 32'h11BB33DD, 32'hDEADBEEF}};
      vt[10] = '{"wr3x",   3'b111, 3'b111, {6'd12, 6'd11, 6'd10}, {32'hC, 32'hB, 32'hA}, {4'hF, 4'hF, 4'hF}, 3'b111, 3'b000, 3'b111, {32'h0, 32'h11BB33DD, 32'hDEADBEEF}};
      vt[11] = '{"rd3y",   3'b111, 3'b000, {6'd11, 6'd10, 6'd12}, '0, '0, 3'b111, 3'b111, 3'b111, {32'hB, 32'hA, 32'hC}};
      vt[12] = '{"idle",   3'b000, 3'b111, {6'd12, 6'd11, 6'd10}, {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}, {4'hF, 4'hF, 4'hF}, 3'b000, 3'b000, 3'b111, {32'hB, 32'hA, 32'hC}};
      vt[13] = '{"wr20x3", 3'b111, 3'b111, {6'd20, 6'd20, 6'd20}, {32'h300, 32'h200, 32'h100}, {4'hF, 4'hF, 4'hF}, 3'b001, 3'b000, 3'b000, '0};
      vt[14] = '{"rd20",   3'b011, 3'b001, {6'd0, 6'd20, 6'd50},  {32'h0, 32'h0, 32'hFFFFFFFF}, {4'h0, 4'h0, 4'hF}, 3'b011, 3'b010, 3'b010, {32'h0, 32'h100, 32'h0}};
      vt[15] = '{"rd10",   3'b100, 3'b000, {6'd10, 6'd0, 6'd0},   '0, '0, 3'b100, 3'b100, 3'b100, {32'hA, 32'h0, 32'h0}};

      l1_req = '1; l1_we = '0; l1_addr = '0; l1_wdata = '0; l1_be = '0;
      l0_req = '1; l0_we = '0; l0_addr = '0; l0_wdata = '0; l0_be = '0;

      #2;
      chk("rst_gnt_l1", {29'd0, l1_gnt}, 32'd0);
      chk("rst_gnt_l0", {30'd0, l0_gnt}, 32'd0);
      @(posedge clk); #1;
      chk("rst_rvalid_l1", {29'd0, l1_rvalid}, 32'd0);
      chk("rst_rdata_l1_p0", l1_rdata[31:0], 32'd0);
      chk("rst_rdata_l1_p2", l1_rdata[95:64], 32'd0);
      chk("rst_rvalid_l0", {30'd0, l0_rvalid}, 32'd0);

`ifdef TC_SRAM_LATCH_MP_INIT_EN
      chk("rst_init_done", {30'd0, l1_done, l0_done}, 32'd0);
      rst = 1'b0;
      count_init(n0, n1, gbad);
      chk("init_cycles_16", n0, 16);
      chk("init_cycles_48", n1, 48);
      chk("init_gnt_zero", gbad, 0);
      rst = 1'b1; #2; rst = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("init_mid_done", {31'd0, l0_done}, 32'd0);
      rst = 1'b1; #2; rst = 1'b0;
      count_init(n0, n1, gbad);
      chk("reinit_cycles_16", n0, 16);
      chk("reinit_cycles_48", n1, 48);
      chk("reinit_gnt_zero", gbad, 0);
      l1_req = '0; l0_req = 2'b01;
      for (int i = 0; i < 16; i++) begin
         l0_addr = {4'd0, 4'(i)};
         @(posedge clk); #1;
         chk($sformatf("init_zero_l0_%0d", i), {20'd0, l0_rdata[11:0]}, 32'd0);
      end
      l0_req = '0; l1_req = 3'b001;
      for (int i = 0; i < 48; i++) begin
         l1_addr = 18'(i);
         @(posedge clk); #1;
         chk($sformatf("init_zero_l1_%0d", i), l1_rdata[31:0], 32'd0);
      end
`else
      rst = 1'b0;
      chk("init_done_const", {30'd0, l1_done, l0_done}, 32'd3);
`endif
      l1_req = '0; l0_req = '0;
      @(posedge clk); #1;

      for (int i = 0; i < 16; i++) begin
         l1_req = vt[i].req; l1_we = vt[i].we; l1_addr = vt[i].a;
         l1_wdata = vt[i].d; l1_be = vt[i].b;
         #2;
         chk($sformatf("%s.gnt", vt[i].name), {29'd0, l1_gnt}, {29'd0, vt[i].gnt});
         @(posedge clk); #1;
         chk($sformatf("%s.rvalid", vt[i].name), {29'd0, l1_rvalid}, {29'd0, vt[i].rv});
         for (int p = 0; p < 3; p++) begin
            if (vt[i].chk[p]) chk($sformatf("%s.rdata%0d", vt[i].name, p), l1_rdata[p*32 +: 32], vt[i].r[p]);
         end
      end
      l1_req = '0;

      // Latency 0: read-before-write, then new value the next cycle
      l0_req = 2'b01; l0_we = 2'b01; l0_addr = 8'h07; l0_wdata = 24'h000005; l0_be = 4'b0011;
      #2;
      chk("l0_wr7_gnt", {30'd0, l0_gnt}, 32'd1);
      @(posedge clk); #1;
      l0_req = 2'b11; l0_we = 2'b01; l0_addr = {4'd7, 4'd7}; l0_wdata = 24'h000006;
      #1;
      chk("l0_rw_gnt", {30'd0, l0_gnt}, 32'd3);
      chk("l0_rw_rvalid", {30'd0, l0_rvalid}, 32'd2);
      chk("l0_rw_old", {20'd0, l0_rdata[23:12]}, 32'h005);
      @(posedge clk); #1;
      l0_req = 2'b10; l0_we = 2'b00;
      #1;
      chk("l0_rw_new", {20'd0, l0_rdata[23:12]}, 32'h006);
      chk("l0_rd_rvalid", {30'd0, l0_rvalid}, 32'd2);

      // Partial last lane: 12-bit word, lane1 covers bits 11:8
      l0_req = 2'b01; l0_we = 2'b01; l0_addr = 8'h02; l0_wdata = 24'h000FFF; l0_be = 4'b0011;
      @(posedge clk); #1;
      l0_wdata = 24'h000000; l0_be = 4'b0010;
      @(posedge clk); #1;
      l0_req = 2'b10; l0_we = 2'b00; l0_addr = {4'd2, 4'd0};
      #1;
      chk("l0_partial_lane", {20'd0, l0_rdata[23:12]}, 32'h0FF);
      l0_req = 2'b00; l0_we = 2'b11;
      #1;
      chk("l0_noreq_gnt", {30'd0, l0_gnt}, 32'd0);
      chk("l0_noreq_rvalid", {30'd0, l0_rvalid}, 32'd0);
      l0_we = 2'b00;
      @(posedge clk); #1;

      // Out-of-range writes leave every word untouched
      l1_req = 3'b001; l1_we = 3'b001; l1_be = 12'h00F;
      for (int i = 0; i < 48; i++) begin
         l1_addr = 18'(i);
         l1_wdata = 96'(32'h1000 + i);
         @(posedge clk); #1;
      end
      l1_req = 3'b011; l1_we = 3'b011; l1_addr = {6'd0, 6'd63, 6'd50}; l1_wdata = '1; l1_be = '1;
      #2;
      chk("oob_wr_gnt", {29'd0, l1_gnt}, 32'd3);
      @(posedge clk); #1;
      l1_req = 3'b001; l1_we = '0;
      for (int i = 0; i < 48; i++) begin
         l1_addr = 18'(i);
         @(posedge clk); #1;
         chk($sformatf("oob_reread_%0d", i), l1_rdata[31:0], 32'h1000 + i);
      end

      // Reset mid-operation
      l1_addr = 18'd5;
      @(posedge clk); #1;
      chk("mid_rvalid_pre", {29'd0, l1_rvalid}, 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rvalid_rst", {29'd0, l1_rvalid}, 32'd0);
      chk("mid_rdata_rst", l1_rdata[31:0], 32'd0);
      l1_we = 3'b001; l1_addr = 18'd0; l1_wdata = 96'h0BAD; l1_be = 12'h00F;
      #1;
      chk("mid_gnt_rst", {29'd0, l1_gnt}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; l1_req = '0; l1_we = '0;
      wait_ready();
      l1_req = 3'b001; l1_addr = 18'd0;
      @(posedge clk); #1;
`ifdef TC_SRAM_LATCH_MP_INIT_EN
      chk("mid_no_commit", l1_rdata[31:0], 32'h0);
`else
      chk("mid_no_commit", l1_rdata[31:0], 32'h1000);
`endif
      l1_req = '0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
